// File: rtl/spi_rom_pkg.sv
// Shared definitions for the serial-ROM read sequencer: opcode/dummy bytes,
// TX sequencer states and the layout of the 9-bit word pushed into the spiv2 TX FIFO.
package spi_rom_pkg;

    localparam logic [7:0] READ_OP  = 8'h03;
    localparam logic [7:0] DUMMY    = 8'h00;
    localparam int         LAST_BIT = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        A2   = 3'd2,
        A1   = 3'd3,
        A0   = 3'd4,
        DATA = 3'd5,
        WAIT = 3'd6
    } tx_state_t;

    // Bit LAST_BIT tells spiv2 to release chip select after this byte.
    function automatic logic [8:0] make_tx_word(input logic last, input logic [7:0] byte_val);
        logic [8:0] word;
        word           = 9'h000;
        word[LAST_BIT] = last;
        word[7:0]      = byte_val;
        return word;
    endfunction

endpackage

// File: rtl/spi_rom_reader.sv
// Drives the spiv2 TX/RX FIFO pair to read a block from a serial ROM: the TX sequencer
// emits opcode, address and dummy bytes while the RX drain drops the echoes and streams data.
import spi_rom_pkg::*;

module spi_rom_reader #(
    parameter int         LEN_W   = 16,
    parameter logic [7:0] READ_OP = spi_rom_pkg::READ_OP,
    parameter logic [7:0] DUMMY   = spi_rom_pkg::DUMMY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    input  logic [1:0]       freq_cfg,
    output logic             busy,
    output logic             done,
    output logic [1:0]       freq,
    output logic             tx_wr,
    output logic [8:0]       tx_data,
    input  logic             tx_full,
    output logic             rx_rd,
    input  logic [7:0]       rx_data,
    input  logic             rx_empty,
    output logic [7:0]       data_out,
    output logic             data_valid,
    input  logic             data_ready
);

    localparam logic [LEN_W-1:0] TX_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W+2:0] RX_ONE   = {{(LEN_W+2){1'b0}}, 1'b1};
    localparam logic [LEN_W+2:0] RX_ECHOS = {{LEN_W{1'b0}}, 3'd4};

    tx_state_t          state_r;
    logic [23:0]        addr_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   tx_cnt_r;
    logic [LEN_W+2:0]   rx_cnt_r;
    logic [1:0]         freq_r;
    logic               busy_r;
    logic               done_r;

    logic               accept_s;
    logic               tx_en_s;
    logic               tx_wr_s;
    logic [8:0]         tx_word_s;
    logic               discard_s;
    logic               valid_s;
    logic               pop_s;
    logic               last_pop_s;
    logic [7:0]         data_out_s;

    assign accept_s = start && (state_r == IDLE) && !busy_r;

    // Word presented to the TX FIFO in each sequencer state.
    always_comb begin
        tx_en_s   = 1'b0;
        tx_word_s = 9'h000;
        case (state_r)
            CMD: begin
                tx_en_s   = 1'b1;
                tx_word_s = make_tx_word(1'b0, READ_OP);
            end
            A2: begin
                tx_en_s   = 1'b1;
                tx_word_s = make_tx_word(1'b0, addr_r[23:16]);
            end
            A1: begin
                tx_en_s   = 1'b1;
                tx_word_s = make_tx_word(1'b0, addr_r[15:8]);
            end
            A0: begin
                tx_en_s   = 1'b1;
                tx_word_s = make_tx_word(1'b0, addr_r[7:0]);
            end
            DATA: begin
                tx_en_s   = 1'b1;
                tx_word_s = make_tx_word(tx_cnt_r == TX_ONE, DUMMY);
            end
            default: begin
                tx_en_s   = 1'b0;
                tx_word_s = 9'h000;
            end
        endcase
        if (tx_en_s && !tx_full) begin
            tx_wr_s = 1'b1;
        end else begin
            tx_wr_s = 1'b0;
        end
    end

    // RX drain: the first four bytes received are echoes of opcode/address and are dropped.
    always_comb begin
        discard_s  = 1'b0;
        valid_s    = 1'b0;
        pop_s      = 1'b0;
        last_pop_s = 1'b0;
        data_out_s = 8'h00;
        if (busy_r) begin
            discard_s = (rx_cnt_r > {3'b000, len_r});
            if (discard_s) begin
                pop_s = !rx_empty;
            end else begin
                valid_s    = !rx_empty;
                pop_s      = !rx_empty && data_ready;
                data_out_s = rx_data;
            end
            last_pop_s = pop_s && (rx_cnt_r == RX_ONE);
        end else begin
            discard_s = 1'b0;
        end
    end

    // TX sequencer: latches the request and advances only on an actual FIFO write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            addr_r   <= 24'h000000;
            len_r    <= {LEN_W{1'b0}};
            freq_r   <= 2'b00;
            tx_cnt_r <= {LEN_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r   <= addr;
                        len_r    <= len;
                        freq_r   <= freq_cfg;
                        tx_cnt_r <= len;
                        if (len != {LEN_W{1'b0}}) begin
                            state_r <= CMD;
                        end
                    end
                end
                CMD: if (tx_wr_s) state_r <= A2;
                A2:  if (tx_wr_s) state_r <= A1;
                A1:  if (tx_wr_s) state_r <= A0;
                A0:  if (tx_wr_s) state_r <= DATA;
                DATA: begin
                    if (tx_wr_s) begin
                        tx_cnt_r <= tx_cnt_r - TX_ONE;
                        if (tx_cnt_r == TX_ONE) begin
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: if (last_pop_s) state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // RX byte accounting and the busy/done handshake with the host.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            rx_cnt_r <= {(LEN_W+3){1'b0}};
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                if (len == {LEN_W{1'b0}}) begin
                    done_r <= 1'b1;
                end else begin
                    busy_r   <= 1'b1;
                    rx_cnt_r <= {3'b000, len} + RX_ECHOS;
                end
            end else if (pop_s) begin
                rx_cnt_r <= rx_cnt_r - RX_ONE;
                if (last_pop_s) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign freq       = freq_r;
    assign tx_wr      = tx_wr_s;
    assign tx_data    = tx_word_s;
    assign rx_rd      = pop_s;
    assign data_valid = valid_s;
    assign data_out   = data_out_s;

endmodule

// File: tb/tb_spi_rom_reader.sv
// Bench for spi_rom_reader: a queue-based spiv2/ROM model answers each dummy byte with
// the next expected ROM byte, and directed plus random transfers are checked against it.
module tb_spi_rom_reader;

    localparam int LEN_W    = 16;
    localparam int TX_DEPTH = 4;
    localparam int RX_DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [23:0]      addr = 24'h000000;
    logic [LEN_W-1:0] len = '0;
    logic [1:0]       freq_cfg = 2'b00;
    logic             busy, done, tx_wr, rx_rd, data_valid;
    logic [1:0]       freq;
    logic [8:0]       tx_data;
    logic [7:0]       data_out;
    logic             tx_full = 1'b0;
    logic             rx_empty = 1'b1;
    logic [7:0]       rx_data = 8'h00;
    logic             data_ready = 1'b1;

    spi_rom_reader #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .len(len), .freq_cfg(freq_cfg),
        .busy(busy), .done(done), .freq(freq), .tx_wr(tx_wr), .tx_data(tx_data),
        .tx_full(tx_full), .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready)
    );

    always #5 clk = ~clk;

    logic [8:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] rom_q[$];
    logic [7:0] exp_q[$];
    logic [8:0] tx_log[$];
    logic [8:0] exp_tx[$];
    int frame_idx = 0;
    int shift_timer = 0;
    int done_cnt = 0, wr_cnt = 0, rd_cnt = 0, busy_cnt = 0;
    int done_base = 0;
    bit force_full = 1'b0;
    int ready_mode = 0;
    int checks = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // spiv2 + ROM model: inputs change on negedge, DUT requests are taken 1ns later.
    always @(negedge clk) begin
        logic [8:0] w;
        logic [7:0] b, e;
        if (shift_timer > 0) begin
            shift_timer--;
        end else if (tx_q.size() > 0 && rx_q.size() < RX_DEPTH) begin
            w = tx_q.pop_front();
            frame_idx++;
            if (frame_idx <= 4) b = 8'hF0;
            else if (rom_q.size() > 0) b = rom_q.pop_front();
            else b = 8'h5A;
            rx_q.push_back(b);
            if (w[8]) frame_idx = 0;
            shift_timer = 2;
        end
        data_ready = (ready_mode == 0) ? 1'b1 :
                     (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        tx_full  = force_full || (tx_q.size() >= TX_DEPTH);
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_q[0];
        #1;
        if (rst) begin
            tx_q.delete(); rx_q.delete(); rom_q.delete(); exp_q.delete();
            frame_idx = 0; shift_timer = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (tx_wr) begin
                check("tx_wr_while_full", tx_full, 1'b0);
                tx_log.push_back(tx_data);
                tx_q.push_back(tx_data);
                wr_cnt++;
            end
            if (rx_rd) begin
                check("rx_rd_while_empty", rx_empty, 1'b0);
                if (rx_q.size() > 0) void'(rx_q.pop_front());
                rd_cnt++;
            end
            if (data_valid && data_ready) begin
                check("payload_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("payload_byte", data_out, e);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic begin_xfer(input logic [23:0] a, input logic [LEN_W-1:0] n, input logic [1:0] f);
        if (rom_q.size() == 0) begin
            for (int i = 0; i < int'(n); i++) rom_q.push_back(8'($urandom));
        end
        exp_q = rom_q;
        exp_tx.delete();
        if (n != 0) begin
            exp_tx.push_back({1'b0, 8'h03});
            exp_tx.push_back({1'b0, a[23:16]});
            exp_tx.push_back({1'b0, a[15:8]});
            exp_tx.push_back({1'b0, a[7:0]});
            for (int i = 0; i < int'(n); i++) exp_tx.push_back({(i == int'(n) - 1), 8'h00});
        end
        tx_log.delete();
        done_base = done_cnt;
        @(negedge clk);
        addr = a; len = n; freq_cfg = f; start = 1'b1;
        @(negedge clk);
        start = 1'b0; addr = 24'($urandom); len = LEN_W'($urandom_range(1, 50)); freq_cfg = ~f;
        #2;
        if (n != 0) begin
            check("busy_after_start", busy, 1'b1);
            check("freq_latched", freq, f);
        end else begin
            check("len0_done", done, 1'b1);
            check("len0_busy", busy, 1'b0);
        end
    endtask

    task automatic finish_xfer(input string tag);
        int budget;
        budget = 0;
        while (done_cnt == done_base && budget < 3000) begin
            tick();
            budget++;
        end
        check($sformatf("%s_done_seen", tag), done_cnt != done_base, 1'b1);
        check($sformatf("%s_busy_with_done", tag), busy, 1'b0);
        repeat (3) tick();
        check($sformatf("%s_one_done", tag), done_cnt - done_base, 1);
        check($sformatf("%s_payload_left", tag), exp_q.size(), 0);
        check($sformatf("%s_tx_count", tag), tx_log.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
            check($sformatf("%s_tx_word%0d", tag, i), tx_log[i], exp_tx[i]);
    endtask

    task automatic wait_tx(input int n);
        int budget;
        budget = 0;
        while (tx_log.size() < n && budget < 200) begin
            tick();
            budget++;
        end
        check("wait_tx_reached", tx_log.size() >= n, 1'b1);
    endtask

    initial begin
        int wr0, rd0, bz0;
        logic [7:0] held;

        // Reset state
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tx_wr", tx_wr, 1'b0);
        check("rst_tx_data", tx_data, 9'h000);
        check("rst_rx_rd", rx_rd, 1'b0);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_freq", freq, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 1: basic read, known payload
        rom_q = '{8'hAA, 8'hBB, 8'hCC};
        begin_xfer(24'h012345, 3, 2'b01);
        finish_xfer("t1");

        // 2: zero length
        wr0 = wr_cnt; rd0 = rd_cnt; bz0 = busy_cnt; done_base = done_cnt;
        begin_xfer(24'h777777, 0, 2'b10);
        tick();
        check("len0_done_one_cycle", done, 1'b0);
        repeat (5) tick();
        check("len0_no_tx", wr_cnt - wr0, 0);
        check("len0_no_rx", rd_cnt - rd0, 0);
        check("len0_never_busy", busy_cnt - bz0, 0);
        check("len0_done_count", done_cnt - done_base, 1);

        // 3: TX FIFO full mid-address
        begin_xfer(24'hABCDEF, 2, 2'b11);
        wait_tx(2);
        force_full = 1'b1;
        tick();
        wr0 = wr_cnt;
        repeat (5) tick();
        check("full_no_writes", wr_cnt - wr0, 0);
        check("full_tx_wr_low", tx_wr, 1'b0);
        force_full = 1'b0;
        finish_xfer("t3");

        // 4: consumer stall during payload
        begin_xfer(24'h100000, 8, 2'b00);
        while (exp_q.size() > 7 && done_cnt == done_base) tick();
        ready_mode = 2;
        tick();
        rd0 = rd_cnt;
        held = exp_q.size() > 0 ? exp_q[0] : 8'h00;
        repeat (20) tick();
        check("stall_no_pops", rd_cnt - rd0, 0);
        check("stall_valid_held", data_valid, 1'b1);
        check("stall_data_stable", data_out, held);
        check("stall_remaining", exp_q.size(), 7);
        ready_mode = 0;
        finish_xfer("t4");

        // 5: start while busy is ignored
        begin_xfer(24'h0A0B0C, 5, 2'b01);
        repeat (3) tick();
        @(negedge clk);
        addr = 24'hFFFFFF; len = 2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_xfer("t5");

        // 6: reset during A1, then a fresh one-byte read
        begin_xfer(24'h123456, 4, 2'b11);
        wait_tx(2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_tx_wr", tx_wr, 1'b0);
        check("abort_tx_data", tx_data, 9'h000);
        check("abort_rx_rd", rx_rd, 1'b0);
        check("abort_data_valid", data_valid, 1'b0);
        check("abort_freq", freq, 2'b00);
        tick();
        begin_xfer(24'h000000, 1, 2'b10);
        finish_xfer("t6");

        // Random transfers with random consumer backpressure
        ready_mode = 1;
        for (int k = 0; k < 6; k++) begin
            begin_xfer(24'($urandom), LEN_W'($urandom_range(1, 12)), 2'($urandom_range(0, 3)));
            finish_xfer($sformatf("rnd%0d", k));
        end
        ready_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
